// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared fetch constants and sequencer state type
package pc_fetch_unit_pkg;
  localparam int PC_W = 10;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: circular return-address stack; push when full overwrites the oldest entry
module ret_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  import pc_fetch_unit_pkg::*;
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW:0] cnt;
  assign top = mem[ptr - 1'b1];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      mem[ptr] <= din;
      ptr <= ptr + 1'b1;
      cnt <= full ? cnt : cnt + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencer (start, linear fetch, branch, call/return, stall, halt)
module pc_fetch_unit #(
  parameter int PC_W = pc_fetch_unit_pkg::PC_W,
  parameter int START_ADDR = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            take_branch,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            halt_req,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            done,
  output logic            stk_ovf,
  output logic            stk_unf
);
  import pc_fetch_unit_pkg::*;
  fetch_state_t state;
  logic [PC_W-1:0] pc_inc, tos, pc_nxt;
  logic act, push, pop, clr, full, empty;
  assign act = state == RUN && !stall && !halt_req;
  assign push = act && is_call && !is_ret;
  assign pop = act && is_ret;
  assign clr = reset || (state == HALT && start);
  assign pc_inc = pc + 1'b1;
  assign pc_nxt = is_ret ? (empty ? pc_inc : tos) : (is_call || take_branch) ? branch_target : pc_inc;
  assign fetch_valid = state == RUN;
  ret_addr_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk(clk), .clr(clr), .push(push), .pop(pop), .din(pc_inc),
    .top(tos), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= PC_W'(START_ADDR);
      done <= 1'b0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pc <= PC_W'(START_ADDR);
          state <= RUN;
        end
        RUN: if (act) begin
          pc <= pc_nxt;
          stk_unf <= stk_unf | (is_ret & empty);
          stk_ovf <= stk_ovf | (is_call & !is_ret & full);
        end else if (!stall) begin
          state <= HALT;
          done <= 1'b1;
        end
        HALT: if (start) begin
          pc <= PC_W'(START_ADDR);
          done <= 1'b0;
          stk_ovf <= 1'b0;
          stk_unf <= 1'b0;
          state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
